bridge_deadtime_guard: RTL and testbench

- Parametrised gate-drive guard between the commutation/PWM logic and the bridge pins of the N-phase motor controller.
- Takes raw per-phase high-side and low-side drive requests and produces the pin drives.
- Enforces a programmable dead time on every high/low transition.
- Turns a request for both switches of one leg into a latched shoot-through fault with all switches off.
- Generalises the fixed 3-phase output-pattern checks into an active, N-phase, counting protection block.

---
 rtl/bridge_deadtime_guard.sv | 153 +++++++++++++++
 tb/tb_bridge_deadtime_guard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_deadtime_guard.sv
`default_nettype none
// ============================================================================
// Module   : bridge_deadtime_guard
// Brief    : N-phase gate-drive guard with per-leg dead time and a latched
//            shoot-through fault that forces every switch off.
// Revision : 1.0
// ============================================================================
module bridge_deadtime_guard #(
    parameter int PHASES   = 3,
    parameter int DEAD_CYC = 50,
    parameter int DEAD_W   = 8,
    parameter int CNT_W    = 8
) (
    input  logic              clk50mhzI,
    input  logic              rstI,
    input  logic [PHASES-1:0] hReqI,
    input  logic [PHASES-1:0] lReqI,
    input  logic              forceStopI,
    input  logic              faultClrI,
    output logic [PHASES-1:0] hPo,
    output logic [PHASES-1:0] lNo,
    output logic              faultO,
    output logic [PHASES-1:0] faultPhO,
    output logic [CNT_W-1:0]  faultCntO
);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_HON  = 2'd1,
        S_LON  = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    localparam logic [DEAD_W-1:0] C_DEAD_LOAD = DEAD_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX   = {CNT_W{1'b1}};

    logic [PHASES-1:0] w_shoot;
    logic              w_shoot_any;
    logic              w_hold;

    logic              r_fault;
    logic [PHASES-1:0] r_fault_ph;
    logic [CNT_W-1:0]  r_fault_cnt;

    assign w_shoot     = hReqI & lReqI;
    assign w_shoot_any = |w_shoot;
    // Legs are frozen off while latched, while a shoot-through is being
    // requested right now, or while the controller commands a stop.
    assign w_hold      = r_fault | w_shoot_any | forceStopI;

    always_ff @(posedge clk50mhzI) begin
        if (rstI) begin
            r_fault     <= 1'b0;
            r_fault_ph  <= '0;
            r_fault_cnt <= '0;
        end else begin
            if (w_shoot_any) begin
                r_fault    <= 1'b1;
                r_fault_ph <= r_fault_ph | w_shoot;
                if (!r_fault && (r_fault_cnt != C_CNT_MAX)) begin
                    r_fault_cnt <= r_fault_cnt + CNT_W'(1);
                end
            end else if (faultClrI) begin
                r_fault    <= 1'b0;
                r_fault_ph <= '0;
            end
        end
    end

    assign faultO    = r_fault;
    assign faultPhO  = r_fault_ph;
    assign faultCntO = r_fault_cnt;

    for (genvar i = 0; i < PHASES; i++) begin : g_phase
        state_t            r_state;
        state_t            w_state_nxt;
        state_t            w_idle_nxt;
        logic [DEAD_W-1:0] r_cnt;
        logic [DEAD_W-1:0] w_cnt_nxt;
        logic              r_hp;
        logic              r_ln;
        logic              w_want_h;
        logic              w_want_l;

        assign w_want_h = hReqI[i] & ~lReqI[i];
        assign w_want_l = lReqI[i] & ~hReqI[i];

        always_comb begin
            w_idle_nxt = S_OFF;
            if (!w_hold) begin
                if (w_want_h) begin
                    w_idle_nxt = S_HON;
                end else if (w_want_l) begin
                    w_idle_nxt = S_LON;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_OFF: begin
                    w_state_nxt = w_idle_nxt;
                end
                S_HON: begin
                    if (w_hold || !w_want_h) begin
                        w_state_nxt = S_DEAD;
                        w_cnt_nxt   = C_DEAD_LOAD;
                    end
                end
                S_LON: begin
                    if (w_hold || !w_want_l) begin
                        w_state_nxt = S_DEAD;
                        w_cnt_nxt   = C_DEAD_LOAD;
                    end
                end
                S_DEAD: begin
                    // The count is never reloaded here, so request churn
                    // cannot stretch or shorten the off window.
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - DEAD_W'(1);
                    end else begin
                        w_state_nxt = w_idle_nxt;
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge clk50mhzI) begin
            if (rstI) begin
                r_state <= S_OFF;
                r_cnt   <= '0;
                r_hp    <= 1'b0;
                r_ln    <= 1'b1;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_hp    <= (w_state_nxt == S_HON);
                r_ln    <= (w_state_nxt != S_LON);
            end
        end

        assign hPo[i] = r_hp;
        assign lNo[i] = r_ln;
    end

endmodule
`default_nettype wire

// File: tb/tb_bridge_deadtime_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_bridge_deadtime_guard
// Brief    : Directed self-checking bench for bridge_deadtime_guard.
// Revision : 1.0
// ============================================================================
module tb_bridge_deadtime_guard;

    localparam int PHASES   = 3;
    localparam int DEAD_CYC = 4;
    localparam int DEAD_W   = 8;
    localparam int CNT_W    = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [PHASES-1:0] hReq;
    logic [PHASES-1:0] lReq;
    logic              fstop;
    logic              fclr;
    logic [PHASES-1:0] hPo;
    logic [PHASES-1:0] lNo;
    logic              faultO;
    logic [PHASES-1:0] faultPh;
    logic [CNT_W-1:0]  faultCnt;

    int total = 0;
    int bad   = 0;
    bit inv_en = 1'b0;

    always #5 clk = ~clk;

    bridge_deadtime_guard #(
        .PHASES   (PHASES),
        .DEAD_CYC (DEAD_CYC),
        .DEAD_W   (DEAD_W),
        .CNT_W    (CNT_W)
    ) u_dut (
        .clk50mhzI  (clk),
        .rstI       (rst),
        .hReqI      (hReq),
        .lReqI      (lReq),
        .forceStopI (fstop),
        .faultClrI  (fclr),
        .hPo        (hPo),
        .lNo        (lNo),
        .faultO     (faultO),
        .faultPhO   (faultPh),
        .faultCntO  (faultCnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [PHASES-1:0] h, input logic [PHASES-1:0] l);
        hReq = h;
        lReq = l;
    endtask

    // A leg must never have its high side on while its low side is on.
    always @(negedge clk) begin
        if (inv_en) begin
            total++;
            assert ((hPo & ~lNo) === 3'b000)
            else begin
                bad++;
                $error("FAIL invariant observed hPo=%b lNo=%b expected no overlap", hPo, lNo);
            end
        end
    end

    initial begin
        rst = 1'b1; fstop = 1'b0; fclr = 1'b0;
        drive(3'b000, 3'b000);
        step();
        step();
        chk("rst_hPo", 32'(hPo), 32'h0);
        chk("rst_lNo", 32'(lNo), 32'h7);
        chk("rst_fault", 32'(faultO), 32'h0);
        chk("rst_faultPh", 32'(faultPh), 32'h0);
        chk("rst_faultCnt", 32'(faultCnt), 32'h0);
        rst = 1'b0;
        inv_en = 1'b1;
        step();

        // High side of phase 0, then hand over to the low side.
        drive(3'b001, 3'b000);
        step();
        chk("hon_hPo", 32'(hPo), 32'h1);
        chk("hon_lNo", 32'(lNo), 32'h7);
        drive(3'b000, 3'b001);
        step();
        chk("dead0_hPo", 32'(hPo), 32'h0);
        chk("dead0_lNo", 32'(lNo), 32'h7);
        for (int k = 1; k < DEAD_CYC; k++) begin
            step();
            chk("dead0_hold_lNo", 32'(lNo), 32'h7);
        end
        step();
        chk("lon0_lNo", 32'(lNo), 32'h6);
        chk("lon0_hPo", 32'(hPo), 32'h0);

        // Phase 1 low side, then toggle the request while in dead time.
        drive(3'b000, 3'b011);
        step();
        chk("lon1_lNo", 32'(lNo), 32'h4);
        drive(3'b000, 3'b001);
        step();
        chk("dead1_e0", 32'(lNo), 32'h6);
        drive(3'b000, 3'b011);
        step();
        chk("dead1_e1", 32'(lNo), 32'h6);
        drive(3'b000, 3'b001);
        step();
        chk("dead1_e2", 32'(lNo), 32'h6);
        drive(3'b000, 3'b011);
        step();
        chk("dead1_e3", 32'(lNo), 32'h6);
        step();
        chk("dead1_exit_on", 32'(lNo), 32'h4);
        drive(3'b000, 3'b001);
        for (int k = 0; k < DEAD_CYC; k++) step();
        step();
        chk("dead1_exit_off", 32'(lNo), 32'h6);

        // Go idle and let all dead timers expire.
        drive(3'b000, 3'b000);
        for (int k = 0; k < DEAD_CYC + 2; k++) step();
        chk("idle_lNo", 32'(lNo), 32'h7);

        // Shoot-through on phase 2 while it conducts high.
        drive(3'b100, 3'b000);
        step();
        chk("hon2_hPo", 32'(hPo), 32'h4);
        drive(3'b100, 3'b100);
        step();
        chk("st_fault", 32'(faultO), 32'h1);
        chk("st_faultPh", 32'(faultPh), 32'h4);
        chk("st_faultCnt", 32'(faultCnt), 32'h1);
        chk("st_hPo", 32'(hPo), 32'h0);
        chk("st_lNo", 32'(lNo), 32'h7);
        drive(3'b010, 3'b000);
        step();
        chk("held_hPo", 32'(hPo), 32'h0);
        drive(3'b001, 3'b001);
        step();
        chk("st2_faultPh", 32'(faultPh), 32'h5);
        chk("st2_faultCnt", 32'(faultCnt), 32'h1);

        // Clear attempted during a shoot request is ignored.
        fclr = 1'b1;
        step();
        chk("clr_blocked_fault", 32'(faultO), 32'h1);
        chk("clr_blocked_faultPh", 32'(faultPh), 32'h5);
        drive(3'b000, 3'b000);
        step();
        fclr = 1'b0;
        chk("clr_fault", 32'(faultO), 32'h0);
        chk("clr_faultPh", 32'(faultPh), 32'h0);
        chk("clr_faultCnt", 32'(faultCnt), 32'h1);
        drive(3'b010, 3'b000);
        step();
        chk("resume_hPo", 32'(hPo), 32'h2);
        drive(3'b000, 3'b000);
        for (int k = 0; k < DEAD_CYC + 1; k++) step();

        // Force-stop while phase 0 is on the low side.
        drive(3'b000, 3'b001);
        step();
        chk("lon_pre_stop", 32'(lNo), 32'h6);
        fstop = 1'b1;
        step();
        chk("stop_lNo", 32'(lNo), 32'h7);
        chk("stop_fault", 32'(faultO), 32'h0);
        for (int k = 0; k < DEAD_CYC; k++) step();
        chk("stop_held_lNo", 32'(lNo), 32'h7);
        fstop = 1'b0;
        step();
        chk("stop_release_lNo", 32'(lNo), 32'h6);
        chk("stop_faultCnt", 32'(faultCnt), 32'h1);
        drive(3'b000, 3'b000);
        for (int k = 0; k < DEAD_CYC + 1; k++) step();

        // Forced stop together with a shoot request still latches.
        fstop = 1'b1;
        drive(3'b010, 3'b010);
        step();
        chk("stop_st_fault", 32'(faultO), 32'h1);
        chk("stop_st_faultCnt", 32'(faultCnt), 32'h2);
        fstop = 1'b0;
        drive(3'b000, 3'b000);
        fclr = 1'b1;
        step();
        fclr = 1'b0;

        // 300 fault/clear cycles: count starts at 2 and saturates at 255.
        for (int n = 0; n < 300; n++) begin
            drive(3'b001, 3'b001);
            step();
            if (n == 99) chk("sat_mid", 32'(faultCnt), 32'd102);
            drive(3'b000, 3'b000);
            fclr = 1'b1;
            step();
            fclr = 1'b0;
        end
        chk("sat_cnt", 32'(faultCnt), 32'd255);
        chk("sat_fault_clear", 32'(faultO), 32'h0);

        // Random request streams, covered by the invariant monitor.
        for (int n = 0; n < 600; n++) begin
            hReq  = 3'($urandom_range(0, 7));
            lReq  = 3'($urandom_range(0, 7)) & ~(($urandom_range(0, 3) != 0) ? hReq : 3'b000);
            fstop = ($urandom_range(0, 15) == 0);
            fclr  = ($urandom_range(0, 7) == 0);
            step();
        end

        // Reset overrides a simultaneous shoot request.
        rst = 1'b1;
        fstop = 1'b0;
        fclr = 1'b0;
        drive(3'b111, 3'b111);
        step();
        chk("rst2_fault", 32'(faultO), 32'h0);
        chk("rst2_faultCnt", 32'(faultCnt), 32'h0);
        chk("rst2_lNo", 32'(lNo), 32'h7);
        chk("rst2_hPo", 32'(hPo), 32'h0);

        inv_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
